// File: rtl/demux4way16_router.sv
// demux4way16_router: steers a valid/ready stream of WIDTH-bit words into one of
// four 1-entry holding registers chosen by in_sel. Each channel drains on its own
// valid/ready handshake. A run/drain FSM lets the consumer side be quiesced
// before reconfiguration.
// Optional feature macro: DEMUX4WAY16_ROUTER_STATS_EN adds saturating per-channel
// delivery counters cnt0..cnt3.
module demux4way16_router #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       state,
  output logic             busy
`ifdef DEMUX4WAY16_ROUTER_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] data_r [4];
  logic [3:0]       valid_r;
  logic [3:0]       load_s;
  logic [3:0]       deliver_s;
  logic             ready_s;
  logic             accept_s;

  // A channel can take a new word when empty, or when its current word leaves this cycle.
  assign ready_s   = (state_r == ST_RUN) & (~valid_r[in_sel] | out_ready[in_sel]);
  assign accept_s  = in_valid & ready_s;
  assign deliver_s = valid_r & out_ready;

  // Decode the accepted word into a one-hot channel load strobe.
  always_comb begin
    load_s = 4'b0000;
    if (accept_s) begin
      load_s[in_sel] = 1'b1;
    end else begin
      load_s = 4'b0000;
    end
  end

  // Holding registers: load wins over delivery so back-to-back words see no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 4'b0000;
      for (int k = 0; k < 4; k++) data_r[k] <= {WIDTH{1'b0}};
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load_s[k]) begin
          data_r[k]  <= in_data;
          valid_r[k] <= 1'b1;
        end else if (deliver_s[k]) begin
          valid_r[k] <= 1'b0;
        end
      end
    end
  end

  // Run/drain next-state decision; DRAIN ignores en until every channel is empty.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (en) state_nxt_s = ST_RUN;
        else    state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (en)              state_nxt_s = ST_RUN;
        else if (|valid_r)   state_nxt_s = ST_DRAIN;
        else                 state_nxt_s = ST_IDLE;
      end
      ST_DRAIN: begin
        if ((valid_r & ~deliver_s) == 4'b0000) state_nxt_s = ST_IDLE;
        else                                   state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  assign in_ready  = ready_s;
  assign out0      = data_r[0];
  assign out1      = data_r[1];
  assign out2      = data_r[2];
  assign out3      = data_r[3];
  assign out_valid = valid_r;
  assign state     = state_r;
  assign busy      = (state_r != ST_IDLE);

`ifdef DEMUX4WAY16_ROUTER_STATS_EN
  logic [CNT_W-1:0] cnt_r [4];

  // Per-channel delivery counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) cnt_r[k] <= {CNT_W{1'b0}};
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (deliver_s[k] && (cnt_r[k] != {CNT_W{1'b1}})) begin
          cnt_r[k] <= cnt_r[k] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign cnt0 = cnt_r[0];
  assign cnt1 = cnt_r[1];
  assign cnt2 = cnt_r[2];
  assign cnt3 = cnt_r[3];
`endif

endmodule
